// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding the IF/ID register: req/ready fetch handshake,
// word hold under ifkeep, branch redirect with squash of wrong-path words.
module if_fetch #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifkeep,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              if_valid
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] fetch_addr;
  logic [DATA_W-1:0] pc_inc;

  assign pc_inc   = pc + DATA_W'(1);
  assign mem_req  = rst && ((state == ST_FETCH) || (state == ST_FLUSH));
  assign mem_addr = fetch_addr;
  assign if_valid = (state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      pc_out     <= RESET_PC;
      instr_out  <= NOP_INSTR;
    end else if (branch_taken) begin
      pc        <= branch_target;
      instr_out <= NOP_INSTR;
      // A request still waiting on memory must keep its address until ready.
      if ((state == ST_HOLD) || mem_ready) begin
        fetch_addr <= branch_target;
        state      <= ST_FETCH;
      end else begin
        state <= ST_FLUSH;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            instr_out  <= mem_rdata;
            pc_out     <= pc_inc;
            pc         <= pc_inc;
            fetch_addr <= pc_inc;
            state      <= ST_HOLD;
          end else begin
            instr_out <= NOP_INSTR;
          end
        end
        ST_HOLD: begin
          if (!ifkeep) begin
            instr_out <= NOP_INSTR;
            state     <= ST_FETCH;
          end
        end
        ST_FLUSH: begin
          // Stale word from before the redirect is dropped.
          if (mem_ready) begin
            fetch_addr <= pc;
            state      <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that drives the IF/ID pipeline register: holds the PC, issues fetches to instruction memory over a req/ready handshake, presents each fetched word on `instr_out` and its PC+1 on `pc_out`, and holds that pair under `ifkeep` until IF/ID has latched it. Taken branches redirect the PC and squash wrong-path words. Idle and bubble cycles present a NOP, so IF/ID never latches the same instruction twice.

## Interface
- `RESET_PC`, 16'h0000, first fetch address after reset
- `NOP_INSTR`, 16'h0800, bubble word driven on `instr_out`

- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-low reset
- `ifkeep`  in  1  stall from hazard unit (same signal that holds IF/ID)
- `branch_taken`  in  1  one-cycle redirect pulse
- `branch_target`  in  16  redirect address, valid with `branch_taken`
- `mem_req`  out  1  fetch request
- `mem_addr`  out  16  fetch address
- `mem_ready`  in  1  `mem_rdata` valid this cycle; completes request
- `mem_rdata`  in  16  fetched word
- `pc_out`  out  16  PC+1 of presented instruction (to IF/ID `pc_in`)
- `instr_out`  out  16  presented instruction (to IF/ID `instr_in`)
- `if_valid`  out  1  high while `instr_out` holds a real fetched word

## Operation
- Registers: `pc`, `fetch_addr`, `pc_out`, `instr_out`, 2-bit state {FETCH, HOLD, FLUSH}.
- `mem_req` = `rst` && state in {FETCH, FLUSH}; `mem_addr` = `fetch_addr`; `if_valid` = (state==HOLD).
- Reset (`rst`=0 at posedge): `pc`=`fetch_addr`=RESET_PC, `pc_out`=RESET_PC, `instr_out`=NOP_INSTR, state FETCH. `mem_req`=0 while `rst`=0. An outstanding request is abandoned; memory tolerates this.
- FETCH, no branch, `mem_ready`=0: hold; `instr_out`=NOP_INSTR.
- FETCH, no branch, `mem_ready`=1: `instr_out`<=`mem_rdata`, `pc_out`<=`pc`+1, `pc`<=`pc`+1, `fetch_addr`<=`pc`+1, go to HOLD.
- HOLD: no request. At a posedge with `ifkeep`=0, the word counts as consumed: `instr_out`<=NOP_INSTR, go to FETCH. With `ifkeep`=1, stay in HOLD and keep both outputs stable.
- `branch_taken`=1 at any posedge takes priority over `ifkeep` and `mem_ready`:
  - `pc`<=`branch_target` and `instr_out`<=NOP_INSTR; `pc_out` is unchanged.
  - From HOLD, or from FETCH with `mem_ready`=1: `fetch_addr`<=`branch_target`, go to FETCH; returned data is discarded.
  - From FETCH with `mem_ready`=0: the request must stay stable until ready, so keep `fetch_addr` and go to FLUSH.
  - In FLUSH: `pc` takes the newest target.
- FLUSH: keep requesting the old `fetch_addr`. On `mem_ready`=1, discard data, set `fetch_addr`<=`pc`, go to FETCH.
- Arithmetic: 16-bit, wrap-around (0xFFFF+1 = 0x0000).

## Timing
- Handshake: `mem_addr` is stable from the first cycle `mem_req` is high through the cycle `mem_ready` is sampled high. Zero-wait memory (`mem_ready` tied high) completes in 1 cycle.
- Fetch latency: with no stall, a word appears on `instr_out` at the posedge that samples `mem_ready`=1. Throughput is at most one instruction per 2 cycles (FETCH, HOLD).
- Outputs are posedge-registered and stable across the following negedge, when IF/ID latches them.
- `ifkeep` must be stable from that negedge to the next posedge. The value sampled at posedge is the one IF/ID used.
- Branch: the first target-path request issues the cycle after `branch_taken` (no FLUSH), or the cycle after the old request completes (FLUSH).

## Test plan
- Reset, zero-wait memory returning 0x1000+addr, `ifkeep`=0 -> `instr_out` alternates 0x1000/NOP_INSTR, 0x1001/NOP_INSTR; `pc_out` 0x0001, 0x0002; `mem_addr` 0,1,2.
- 3-wait-state memory -> `mem_addr` stable 4 cycles with `mem_req` high; NOP_INSTR during wait; word valid exactly 1 cycle.
- Word presented, `ifkeep`=1 for 3 cycles -> `instr_out`/`pc_out`/`if_valid` held 4 cycles; no `mem_req`; then NOP_INSTR and next fetch.
- `branch_taken`, target 0x0040, in HOLD with `ifkeep`=1 -> next cycle NOP_INSTR, `if_valid`=0, `mem_addr`=0x0040; next word 0x1040 with `pc_out`=0x0041.
- Branch to 0x0080 mid-wait (addr 0x0005), then branch to 0x0090 -> 0x0005 completes, data dropped; next request 0x0090.
- `pc`=0xFFFF fetch -> `pc_out`=0x0000, next `mem_addr`=0x0000; `rst` low mid-request -> `mem_req` drops, restart at RESET_PC.
